// File: rtl/madd_pkg.sv
// rtl/madd_pkg.sv - shared state encoding and index-width helpers for multiword_add_seq
package madd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } madd_state_t;

    // Chunk index width: $clog2(words), never narrower than one bit.
    function automatic int madd_idx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    localparam int MADD_WORDS_DEF = 4;
    localparam int MADD_IDX_W_DEF = madd_idx_w(MADD_WORDS_DEF);

endpackage

// File: rtl/madd_chunk_adder.sv
// rtl/madd_chunk_adder.sv - N-bit combinational ripple-carry adder from per-bit full adders
module madd_chunk_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    logic [N:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < N; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[N];
    end

endmodule

// File: rtl/multiword_add_seq.sv
// rtl/multiword_add_seq.sv - multi-precision add sequencer, one chunk per cycle; optional MADD_SUB_EN adds A-B
module multiword_add_seq
    import madd_pkg::*;
#(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               cin,
`ifdef MADD_SUB_EN
    input  logic               op_sub,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] sum,
    output logic               cout
);

    localparam int IW = madd_idx_w(WORDS);

    madd_state_t              state, state_nx;
    logic [IW-1:0]            idx;
    logic                     carry;
    logic                     cout_q;
    logic [WORDS-1:0][N-1:0]  a_q, b_q, sum_q;
    logic [N-1:0]             ch_b, ch_s;
    logic                     ch_co;
    logic                     last;
    logic                     load_carry;
    logic                     sub_q;

    assign last = (idx == IW'(WORDS - 1));

`ifdef MADD_SUB_EN
    // Subtract as A + ~B + 1: the +1 rides in on the initial carry.
    assign load_carry = op_sub ? 1'b1 : cin;
    assign ch_b       = sub_q ? ~b_q[idx] : b_q[idx];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sub_q <= 1'b0;
        else if (state == IDLE && in_valid)
            sub_q <= op_sub;
    end
`else
    assign load_carry = cin;
    assign ch_b       = b_q[idx];
    assign sub_q      = 1'b0;
`endif

    madd_chunk_adder #(.N(N)) u_chunk (
        .a  (a_q[idx]),
        .b  (ch_b),
        .ci (carry),
        .s  (ch_s),
        .co (ch_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        sum_q  <= '0;
                        idx    <= '0;
                        carry  <= load_carry;
                        cout_q <= 1'b0;
                    end
                end
                RUN: begin
                    sum_q[idx] <= ch_s;
                    carry      <= ch_co;
                    if (last) begin
                        cout_q <= ch_co;
                        idx    <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decode the state register only, never the inputs.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// tb/tb_multiword_add_seq.sv - directed self-checking bench for multiword_add_seq; covers MADD_SUB_EN when defined
module tb_multiword_add_seq;

    localparam int N = 8;
    localparam int WORDS = 4;
    localparam int W = N * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n;
    int t_prev;

    multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef MADD_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("in_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic accept(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, input logic vs);
        wait_ready();
        a = va; b = vb; cin = vc; op_sub = vs;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk("drain_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        rst_n = 1'b1;
        step();

        accept(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        chk("run_in_ready", 64'(in_ready), 64'd0);
        wait_out_valid();
        chk("latency", 64'(n), 64'd4);
        chk("t1_sum", 64'(sum), 64'h0000_0100);
        chk("t1_cout", 64'(cout), 64'd0);
        drain();

        accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_out_valid();
        chk("t2_sum", 64'(sum), 64'h0000_0000);
        chk("t2_cout", 64'(cout), 64'd1);
        drain();

        accept(32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0);
        wait_out_valid();
        chk("t3_out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_sum", 64'(sum), 64'h2222_2221);
            chk("hold_cout", 64'(cout), 64'd0);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        drain();

        accept(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_sum", 64'(sum), 64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        accept(32'd3, 32'd4, 1'b0, 1'b0);
        wait_out_valid();
        chk("post_abort_sum", 64'(sum), 64'd7);
        chk("post_abort_cout", 64'(cout), 64'd0);
        drain();

`ifdef MADD_SUB_EN
        accept(32'd5, 32'd7, 1'b1, 1'b1);
        wait_out_valid();
        chk("sub1_sum", 64'(sum), 64'hFFFF_FFFE);
        chk("sub1_cout", 64'(cout), 64'd0);
        drain();
        accept(32'd7, 32'd5, 1'b0, 1'b1);
        wait_out_valid();
        chk("sub2_sum", 64'(sum), 64'h0000_0002);
        chk("sub2_cout", 64'(cout), 64'd1);
        drain();
        op_sub = 1'b0;
`endif

        // Back-to-back with the consumer always ready.
        out_ready = 1'b1;
        in_valid = 1'b1;
        t_prev = -1;
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] va, vb, es;
            logic vc, ec;
            case (i)
                0: begin va = 32'h8000_0000; vb = 32'h8000_0000; vc = 1'b0; es = 32'h0000_0000; ec = 1'b1; end
                1: begin va = 32'h0101_0101; vb = 32'h1010_1010; vc = 1'b1; es = 32'h1111_1112; ec = 1'b0; end
                2: begin va = 32'h7FFF_FFFF; vb = 32'h0000_0000; vc = 1'b1; es = 32'h8000_0000; ec = 1'b0; end
                default: begin va = 32'hDEAD_BEEF; vb = 32'h2152_4111; vc = 1'b0; es = 32'h0000_0000; ec = 1'b1; end
            endcase
            wait_ready();
            a = va; b = vb; cin = vc;
            if (t_prev >= 0)
                chk("b2b_spacing", 64'(cyc - t_prev), 64'(WORDS + 2));
            t_prev = cyc;
            step();
            wait_out_valid();
            chk("b2b_sum", 64'(sum), 64'(es));
            chk("b2b_cout", 64'(cout), 64'(ec));
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
